// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, forwarding selects and EX/MEM outputs of the
// execute stage. master drives the ID/EX side, slave is the stage itself.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            i_valid_IDEX;
  logic [XLEN-1:0] i_pc_IDEX;
  logic [XLEN-1:0] i_rs1_data_IDEX;
  logic [XLEN-1:0] i_rs2_data_IDEX;
  logic [XLEN-1:0] i_imm_IDEX;
  logic [4:0]      i_rd_waddr_IDEX;
  logic [3:0]      i_alu_op_IDEX;
  logic            i_alu_src_IDEX;
  logic            i_mul_IDEX;
  logic            i_clu_RegWrite_IDEX;
  logic            i_clu_MemRead_IDEX;
  logic            i_clu_MemWrite_IDEX;
  logic [1:0]      i_forward_A;
  logic [1:0]      i_forward_B;
  logic [XLEN-1:0] i_alu_result_EXMEM;
  logic [XLEN-1:0] i_wb_data_MEMWB;
  logic            i_flush;
  logic            o_valid_EXMEM;
  logic [XLEN-1:0] o_alu_result_EXMEM;
  logic [XLEN-1:0] o_store_data_EXMEM;
  logic [4:0]      o_rd_waddr_EXMEM;
  logic            o_clu_RegWrite_EXMEM;
  logic            o_clu_MemRead_EXMEM;
  logic            o_clu_MemWrite_EXMEM;
  logic            o_busy;

  modport master (
    output i_valid_IDEX, i_pc_IDEX, i_rs1_data_IDEX, i_rs2_data_IDEX,
    output i_imm_IDEX, i_rd_waddr_IDEX, i_alu_op_IDEX, i_alu_src_IDEX,
    output i_mul_IDEX, i_clu_RegWrite_IDEX, i_clu_MemRead_IDEX,
    output i_clu_MemWrite_IDEX, i_forward_A, i_forward_B,
    output i_alu_result_EXMEM, i_wb_data_MEMWB, i_flush,
    input  o_valid_EXMEM, o_alu_result_EXMEM, o_store_data_EXMEM,
    input  o_rd_waddr_EXMEM, o_clu_RegWrite_EXMEM, o_clu_MemRead_EXMEM,
    input  o_clu_MemWrite_EXMEM, o_busy
  );

  modport slave (
    input  i_valid_IDEX, i_pc_IDEX, i_rs1_data_IDEX, i_rs2_data_IDEX,
    input  i_imm_IDEX, i_rd_waddr_IDEX, i_alu_op_IDEX, i_alu_src_IDEX,
    input  i_mul_IDEX, i_clu_RegWrite_IDEX, i_clu_MemRead_IDEX,
    input  i_clu_MemWrite_IDEX, i_forward_A, i_forward_B,
    input  i_alu_result_EXMEM, i_wb_data_MEMWB, i_flush,
    output o_valid_EXMEM, o_alu_result_EXMEM, o_store_data_EXMEM,
    output o_rd_waddr_EXMEM, o_clu_RegWrite_EXMEM, o_clu_MemRead_EXMEM,
    output o_clu_MemWrite_EXMEM, o_busy
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage with operand forwarding, ALU and EX/MEM
// register. Define EX_MUL_EN to add the 33-cycle shift-add multiplier.
module ex_stage (
  input  logic      i_clk,
  input  logic      i_rst,
  ex_stage_if.slave bus
);
  localparam int XLEN = 32;

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b_fwd;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu;
  logic [4:0]      w_shamt;

  logic            w_busy;
  logic            w_done;
  logic [XLEN-1:0] w_mul_res;
  logic [4:0]      w_mul_rd;
  logic            w_mul_rw;
  logic            w_mul_mr;
  logic            w_mul_mw;

  always_comb begin
    case (bus.i_forward_A)
      2'b10:   w_a = bus.i_alu_result_EXMEM;
      2'b01:   w_a = bus.i_wb_data_MEMWB;
      default: w_a = bus.i_rs1_data_IDEX;
    endcase
  end

  always_comb begin
    case (bus.i_forward_B)
      2'b10:   w_b_fwd = bus.i_alu_result_EXMEM;
      2'b01:   w_b_fwd = bus.i_wb_data_MEMWB;
      default: w_b_fwd = bus.i_rs2_data_IDEX;
    endcase
  end

  assign w_b     = bus.i_alu_src_IDEX ? bus.i_imm_IDEX : w_b_fwd;
  assign w_shamt = w_b[4:0];

  always_comb begin
    w_alu = '0;
    case (bus.i_alu_op_IDEX)
      4'd0:  w_alu = w_a + w_b;
      4'd1:  w_alu = w_a - w_b;
      4'd2:  w_alu = w_a << w_shamt;
      4'd3:  w_alu = {{(XLEN-1){1'b0}},
                      $signed(w_a) < $signed(w_b)};
      4'd4:  w_alu = {{(XLEN-1){1'b0}}, w_a < w_b};
      4'd5:  w_alu = w_a ^ w_b;
      4'd6:  w_alu = w_a >> w_shamt;
      4'd7:  w_alu = $signed(w_a) >>> w_shamt;
      4'd8:  w_alu = w_a | w_b;
      4'd9:  w_alu = w_a & w_b;
      4'd10: w_alu = w_b;
      4'd11: w_alu = bus.i_pc_IDEX + XLEN'(4);
      default: w_alu = '0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_start;
  logic            w_step;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_prod;
  logic [4:0]      r_rd;
  logic            r_rw;
  logic            r_mr;
  logic            r_mw;

  assign w_start = bus.i_valid_IDEX & bus.i_mul_IDEX & ~bus.i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.i_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) w_next = S_BUSY;
        S_BUSY: if (r_cnt == 5'd31) w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = ~i_rst & (((r_state == S_IDLE) & w_start) |
                       (r_state == S_BUSY));
    w_step = (r_state == S_BUSY);
    w_done = (r_state == S_DONE);
  end

  // Low XLEN bits of the product do not depend on operand signedness
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_rd     <= '0;
      r_rw     <= 1'b0;
      r_mr     <= 1'b0;
      r_mw     <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_cnt    <= '0;
      r_mcand  <= w_a;
      r_mplier <= w_b;
      r_prod   <= '0;
      r_rd     <= bus.i_rd_waddr_IDEX;
      r_rw     <= bus.i_clu_RegWrite_IDEX;
      r_mr     <= bus.i_clu_MemRead_IDEX;
      r_mw     <= bus.i_clu_MemWrite_IDEX;
    end else if (w_step) begin
      r_cnt    <= r_cnt + 5'd1;
      r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign w_mul_res = r_prod;
  assign w_mul_rd  = r_rd;
  assign w_mul_rw  = r_rw;
  assign w_mul_mr  = r_mr;
  assign w_mul_mw  = r_mw;
`else
  logic w_unused_mul;

  assign w_unused_mul = bus.i_mul_IDEX;
  assign w_busy       = 1'b0;
  assign w_done       = 1'b0;
  assign w_mul_res    = '0;
  assign w_mul_rd     = '0;
  assign w_mul_rw     = 1'b0;
  assign w_mul_mr     = 1'b0;
  assign w_mul_mw     = 1'b0;
`endif

  logic            w_nx_valid;
  logic [XLEN-1:0] w_nx_res;
  logic [XLEN-1:0] w_nx_st;
  logic [4:0]      w_nx_rd;
  logic            w_nx_rw;
  logic            w_nx_mr;
  logic            w_nx_mw;

  always_comb begin
    w_nx_valid = 1'b0;
    w_nx_res   = '0;
    w_nx_st    = '0;
    w_nx_rd    = '0;
    w_nx_rw    = 1'b0;
    w_nx_mr    = 1'b0;
    w_nx_mw    = 1'b0;
    if (!bus.i_flush) begin
      if (w_done) begin
        w_nx_valid = 1'b1;
        w_nx_res   = w_mul_res;
        w_nx_rd    = w_mul_rd;
        w_nx_rw    = w_mul_rw;
        w_nx_mr    = w_mul_mr;
        w_nx_mw    = w_mul_mw;
      end else if (!w_busy && bus.i_valid_IDEX) begin
        w_nx_valid = 1'b1;
        w_nx_res   = w_alu;
        w_nx_st    = w_b_fwd;
        w_nx_rd    = bus.i_rd_waddr_IDEX;
        w_nx_rw    = bus.i_clu_RegWrite_IDEX;
        w_nx_mr    = bus.i_clu_MemRead_IDEX;
        w_nx_mw    = bus.i_clu_MemWrite_IDEX;
      end
    end
  end

  logic            r_valid;
  logic [XLEN-1:0] r_res;
  logic [XLEN-1:0] r_st;
  logic [4:0]      r_rd_q;
  logic            r_rw_q;
  logic            r_mr_q;
  logic            r_mw_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_st    <= '0;
      r_rd_q  <= '0;
      r_rw_q  <= 1'b0;
      r_mr_q  <= 1'b0;
      r_mw_q  <= 1'b0;
    end else begin
      r_valid <= w_nx_valid;
      r_res   <= w_nx_res;
      r_st    <= w_nx_st;
      r_rd_q  <= w_nx_rd;
      r_rw_q  <= w_nx_rw;
      r_mr_q  <= w_nx_mr;
      r_mw_q  <= w_nx_mw;
    end
  end

  assign bus.o_valid_EXMEM        = r_valid;
  assign bus.o_alu_result_EXMEM   = r_res;
  assign bus.o_store_data_EXMEM   = r_st;
  assign bus.o_rd_waddr_EXMEM     = r_rd_q;
  assign bus.o_clu_RegWrite_EXMEM = r_rw_q;
  assign bus.o_clu_MemRead_EXMEM  = r_mr_q;
  assign bus.o_clu_MemWrite_EXMEM = r_mw_q;
  assign bus.o_busy               = w_busy;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of forwarding, ALU ops, EX/MEM bubbles
// and, with EX_MUL_EN, the multiplier stall/flush/reset behaviour.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {23'd0, bus.o_valid_EXMEM, bus.o_clu_RegWrite_EXMEM,
            bus.o_clu_MemRead_EXMEM, bus.o_clu_MemWrite_EXMEM,
            bus.o_rd_waddr_EXMEM};
  endfunction

  task automatic idle();
    bus.i_valid_IDEX        = 1'b0;
    bus.i_pc_IDEX           = '0;
    bus.i_rs1_data_IDEX     = '0;
    bus.i_rs2_data_IDEX     = '0;
    bus.i_imm_IDEX          = '0;
    bus.i_rd_waddr_IDEX     = '0;
    bus.i_alu_op_IDEX       = '0;
    bus.i_alu_src_IDEX      = 1'b0;
    bus.i_mul_IDEX          = 1'b0;
    bus.i_clu_RegWrite_IDEX = 1'b0;
    bus.i_clu_MemRead_IDEX  = 1'b0;
    bus.i_clu_MemWrite_IDEX = 1'b0;
    bus.i_forward_A         = 2'b00;
    bus.i_forward_B         = 2'b00;
    bus.i_alu_result_EXMEM  = '0;
    bus.i_wb_data_MEMWB     = '0;
    bus.i_flush             = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    idle();
    bus.i_valid_IDEX        = 1'b1;
    bus.i_clu_RegWrite_IDEX = 1'b1;
    bus.i_rd_waddr_IDEX     = 5'd1;
    bus.i_alu_op_IDEX       = op;
    bus.i_rs1_data_IDEX     = a;
    bus.i_rs2_data_IDEX     = b;
  endtask

  task automatic vec(input string tag, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e);
    setop(op, a, b);
    tick();
    chk(tag, bus.o_alu_result_EXMEM, e);
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    setop(4'd0, a, b);
    bus.i_mul_IDEX      = 1'b1;
    bus.i_rd_waddr_IDEX = 5'd9;
  endtask

  initial begin
    int  nb;
    bit  bub;
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_res", bus.o_alu_result_EXMEM, 32'h0);
    chk("rst_st", bus.o_store_data_EXMEM, 32'h0);
    chk("rst_ctl", ctl(), 32'h0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    setop(4'd0, 32'd5, 32'd7);
    bus.i_rd_waddr_IDEX    = 5'd3;
    bus.i_forward_A        = 2'b10;
    bus.i_alu_result_EXMEM = 32'd100;
    tick();
    chk("fwdA_ex", bus.o_alu_result_EXMEM, 32'd107);
    chk("fwdA_ctl", ctl(), 32'h183);

    setop(4'd1, 32'd9, 32'd4);
    bus.i_forward_A        = 2'b11;
    bus.i_alu_result_EXMEM = 32'd50;
    bus.i_wb_data_MEMWB    = 32'd60;
    tick();
    chk("fwd11_sub", bus.o_alu_result_EXMEM, 32'd5);

    setop(4'd7, 32'h8000_0000, 32'h0);
    bus.i_alu_src_IDEX = 1'b1;
    bus.i_imm_IDEX     = 32'h21;
    tick();
    chk("sra_imm", bus.o_alu_result_EXMEM, 32'hC000_0000);

    setop(4'd0, 32'h1000, 32'h1111);
    bus.i_clu_RegWrite_IDEX = 1'b0;
    bus.i_clu_MemWrite_IDEX = 1'b1;
    bus.i_rd_waddr_IDEX     = 5'd0;
    bus.i_alu_src_IDEX      = 1'b1;
    bus.i_imm_IDEX          = 32'd8;
    bus.i_forward_B         = 2'b01;
    bus.i_wb_data_MEMWB     = 32'hDEAD_BEEF;
    tick();
    chk("st_addr", bus.o_alu_result_EXMEM, 32'h1008);
    chk("st_data", bus.o_store_data_EXMEM, 32'hDEAD_BEEF);
    chk("st_ctl", ctl(), 32'h120);

    vec("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);
    vec("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    vec("sll", 4'd2, 32'd1, 32'h24, 32'h10);
    vec("slt_t", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
    vec("slt_f", 4'd3, 32'd1, 32'hFFFF_FFFF, 32'd0);
    vec("sltu_f", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
    vec("sltu_t", 4'd4, 32'd1, 32'hFFFF_FFFF, 32'd1);
    vec("xor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    vec("srl", 4'd6, 32'h8000_0000, 32'h1F, 32'd1);
    vec("sra_pos", 4'd7, 32'h4000_0000, 32'd2, 32'h1000_0000);
    vec("or", 4'd8, 32'hF000_0000, 32'hF, 32'hF000_000F);
    vec("and", 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    vec("passb", 4'd10, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000);
    vec("op12", 4'd12, 32'd5, 32'd5, 32'd0);
    vec("op15", 4'd15, 32'd5, 32'd5, 32'd0);

    setop(4'd11, 32'd1, 32'd2);
    bus.i_pc_IDEX = 32'h100;
    tick();
    chk("link", bus.o_alu_result_EXMEM, 32'h104);
    setop(4'd11, 32'd1, 32'd2);
    bus.i_pc_IDEX = 32'hFFFF_FFFC;
    tick();
    chk("link_wrap", bus.o_alu_result_EXMEM, 32'h0);

    setop(4'd0, 32'd3, 32'd4);
    bus.i_valid_IDEX = 1'b0;
    tick();
    chk("inval_res", bus.o_alu_result_EXMEM, 32'h0);
    chk("inval_ctl", ctl(), 32'h0);

    setop(4'd0, 32'd3, 32'd4);
    bus.i_flush = 1'b1;
    tick();
    chk("flush_res", bus.o_alu_result_EXMEM, 32'h0);
    chk("flush_ctl", ctl(), 32'h0);

`ifdef EX_MUL_EN
    start_mul(32'd7, 32'hFFFF_FFFD);
    #1;
    chk("mul_busyT", {31'd0, bus.o_busy}, 32'd1);
    nb  = bus.o_busy ? 1 : 0;
    bub = 1'b1;
    for (int i = 0; i < 40 && bus.o_busy; i++) begin
      tick();
      if (i == 0) bus.i_rs1_data_IDEX = 32'h55;
      if (bus.o_busy) nb++;
      if (bus.o_valid_EXMEM !== 1'b0) bub = 1'b0;
    end
    chk("mul_busy_cnt", nb, 32'd33);
    chk("mul_bubbles", {31'd0, bub}, 32'd1);
    chk("mul_done_busy", {31'd0, bus.o_busy}, 32'd0);
    tick();
    idle();
    chk("mul_res", bus.o_alu_result_EXMEM, 32'hFFFF_FFEB);
    chk("mul_ctl", ctl(), 32'h189);
    tick();
    chk("mul_after", ctl(), 32'h0);

    start_mul(32'd3, 32'd4);
    for (int i = 0; i < 6; i++) tick();
    bus.i_flush = 1'b1;
    chk("fl_busy_in", {31'd0, bus.o_busy}, 32'd1);
    tick();
    idle();
    chk("fl_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("fl_ctl", ctl(), 32'h0);
    bub = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (bus.o_valid_EXMEM !== 1'b0 || bus.o_busy !== 1'b0) bub = 1'b0;
    end
    chk("fl_quiet", {31'd0, bub}, 32'd1);
    vec("fl_add", 4'd0, 32'd10, 32'd20, 32'd30);

    vec("pre_rst", 4'd0, 32'd40, 32'd2, 32'd42);
    start_mul(32'd3, 32'd4);
    for (int i = 0; i < 11; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rstb_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rstb_res", bus.o_alu_result_EXMEM, 32'h0);
    chk("rstb_ctl", ctl(), 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    vec("rstb_add", 4'd0, 32'd1, 32'd2, 32'd3);
    chk("rstb_busy2", {31'd0, bus.o_busy}, 32'd0);
`else
    start_mul(32'd7, 32'hFFFF_FFFD);
    #1;
    chk("nomul_busy", {31'd0, bus.o_busy}, 32'd0);
    tick();
    chk("nomul_res", bus.o_alu_result_EXMEM, 32'd4);
    chk("nomul_busy2", {31'd0, bus.o_busy}, 32'd0);
    chk("nomul_ctl", ctl(), 32'h189);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
